shift_left_2: RTL and testbench
===============================

Name: shift_left_2

Overview:
- Word-offset shifter for the MIPS datapath. It converts a sign-extended 32-bit word offset into a byte offset by shifting left two places, for branch-target and jump-address generation.
- A purely combinational output serves same-cycle datapath use.
- A registered copy with a valid/ready handshake serves pipelined consumers.
- Status flags report the bits shifted out and any signed overflow.

Parameters:
- WIDTH, 32, data width of in/out (all widths below assume the default).
- SHAMT, 2, fixed left-shift amount; must satisfy 1 <= SHAMT < WIDTH.

Ports:
- Clk  input  1  rising-edge clock for the registered stage.
- Rst  input  1  asynchronous, active-high reset.
- in  input  32  operand (word offset).
- out  output  32  combinational result, in << 2.
- in_valid  input  1  in holds an operand to capture into the registered stage.
- in_ready  output  1  registered stage can accept an operand this cycle.
- q  output  32  registered result.
- q_valid  output  1  q, q_lost and q_ovf are valid.
- q_ready  input  1  consumer accepts q this cycle.
- q_lost  output  2  bits shifted out of the captured operand, in[31:30].
- q_ovf  output  1  signed overflow of the captured shift.

Behaviour:
- out = {in[29:0], 2'b00}.
  - Purely combinational; zero latency.
  - Unaffected by Clk and Rst; follows in within the same delta/timestep.
  - The vacated LSBs are always 0.
- Transfer rules:
  - Accept occurs when in_valid && in_ready at a rising Clk edge.
  - Drain occurs when q_valid && q_ready at a rising Clk edge.
  - in_ready = !q_valid || q_ready (combinational), so a simultaneous drain and accept is allowed and throughput is 1 operand/cycle.
- On accept (1-cycle latency):
  - q <= in << 2.
  - q_lost <= in[31:30].
  - q_ovf <= !(in[31] == in[30] && in[30] == in[29]), i.e. the signed value is not representable after the shift.
  - q_valid <= 1.
- On drain without accept: q_valid <= 0; q, q_lost and q_ovf hold their last values.
- With neither event, all registers hold.
- While q_valid=1 and q_ready=0:
  - q and its flags are stable.
  - in_ready=0, and in_valid is ignored.
- Reset, asserted at any time including mid-transfer:
  - Immediately forces q_valid=0, q=0, q_lost=0 and q_ovf=0.
  - Any held result is discarded.
  - in_ready=1 once q_valid=0.
  - out continues to track in throughout.
- After Rst deasserts, the first accept occurs on the next rising edge that sees in_valid=1.
- Boundary values:
  - in=0 gives 0.
  - in=0xFFFFFFFF gives 0xFFFFFFFC with q_lost=3 and q_ovf=0.
  - in=0x40000000 gives 0 with q_lost=1 and q_ovf=1.
  - in=0x20000000 gives 0x80000000 with q_lost=0 and q_ovf=1.
- Outputs never carry X/Z once reset has been applied; inputs are assumed to be known-valued.

Test Plan:
- Combinational sweep, applying in = 0, 1, 2, 4 at 5 ns intervals, with each value checked at the end of its 5 ns interval: out = 0x0, 0x4, 0x8, 0x10, and out never depends on Clk or Rst.
- Register capture:
  - in=0xFFFFFFFF with in_valid=1 and q_ready=1 -> next edge q=0xFFFFFFFC, q_lost=3, q_ovf=0, q_valid=1.
  - in=0x20000000 -> q=0x80000000, q_ovf=1.
  - in=0x40000000 -> q=0, q_lost=1, q_ovf=1.
- Backpressure:
  - Capture 0x00000003 with q_ready=0 -> q=0x0000000C held and in_ready=0.
  - Change in to 0x5 for 3 cycles -> q unchanged.
  - Raise q_ready -> 0x5 is captured the same edge, q=0x14.
- Streaming: in_valid=1 and q_ready=1 with in=1, 2, 3, 4 on consecutive cycles -> q=4, 8, 12, 16 on consecutive cycles, with q_valid continuously 1.
- Drain only: after a capture, in_valid=0 and q_ready=1 -> q_valid falls next edge and q retains its last value.
- Async reset:
  - Assert Rst mid-cycle while q_valid=1 and q=0x10, without a clock edge -> q_valid, q, q_lost and q_ovf go to 0 immediately, and in_ready=1.
  - out still equals in << 2 throughout.

Source files
------------

// File: rtl/shift_left_2.sv
// shift_left_2 - word-offset to byte-offset shifter for the MIPS datapath.
//
// Converts a sign-extended word offset into a byte offset (in << SHAMT) for
// branch-target and jump-address generation. Two views of the result:
//   * out            : combinational, zero latency, independent of Clk/Rst.
//   * q/q_lost/q_ovf : a one-deep registered stage with valid/ready handshake.
//
// Ports:
//   Clk       in   rising-edge clock for the registered stage
//   Rst       in   asynchronous, active-high reset of the registered stage
//   in        in   [WIDTH-1:0] operand (word offset)
//   out       out  [WIDTH-1:0] combinational in << SHAMT
//   in_valid  in   in holds an operand to capture
//   in_ready  out  registered stage can accept an operand this cycle
//   q         out  [WIDTH-1:0] registered result
//   q_valid   out  q, q_lost and q_ovf are valid
//   q_ready   in   consumer accepts q this cycle
//   q_lost    out  [SHAMT-1:0] bits shifted out of the captured operand
//   q_ovf     out  signed overflow of the captured shift
//
// Parameters: WIDTH (data width), SHAMT (fixed shift, 1 <= SHAMT < WIDTH).

module shift_left_2 #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHAMT = 2
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] q,
    output logic             q_valid,
    input  logic             q_ready,
    output logic [SHAMT-1:0] q_lost,
    output logic             q_ovf
);

    logic [SHAMT:0] top_bits;
    logic           ovf_now;
    logic           accept;
    logic           drain;

    always_comb begin
        out = {in[WIDTH-SHAMT-1:0], {SHAMT{1'b0}}};
    end

    // The shifted value stays representable only when the sign bit and every
    // bit shifted out agree, i.e. the top SHAMT+1 bits are all-0 or all-1.
    always_comb begin
        top_bits = in[WIDTH-1 -: SHAMT+1];
        ovf_now  = (top_bits != '0) && (top_bits != '1);
    end

    // A full stage can still accept when it is being drained the same edge,
    // which keeps throughput at one operand per cycle.
    always_comb begin
        in_ready = !q_valid || q_ready;
        accept   = in_valid && in_ready;
        drain    = q_valid && q_ready;
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            q       <= '0;
            q_lost  <= '0;
            q_ovf   <= 1'b0;
            q_valid <= 1'b0;
        end else if (accept) begin
            q       <= out;
            q_lost  <= in[WIDTH-1 -: SHAMT];
            q_ovf   <= ovf_now;
            q_valid <= 1'b1;
        end else if (drain) begin
            q_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_shift_left_2.sv
// tb_shift_left_2 - self-checking bench for shift_left_2.
//
// A transaction-level model (arithmetic on the operand value plus a one-slot
// holding register) predicts every output; a compare process checks the DUT
// against it at each falling edge, and directed steps add literal checks.

`timescale 1ns/1ps

module tb_shift_left_2;

    logic        clk;
    logic        rst;
    logic [31:0] in;
    logic [31:0] out;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] q;
    logic        q_valid;
    logic        q_ready;
    logic [1:0]  q_lost;
    logic        q_ovf;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic        run_chk  = 1'b0;

    shift_left_2 #(.WIDTH(32), .SHAMT(2)) dut (
        .Clk      (clk),
        .Rst      (rst),
        .in       (in),
        .out      (out),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .q        (q),
        .q_valid  (q_valid),
        .q_ready  (q_ready),
        .q_lost   (q_lost),
        .q_ovf    (q_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- model ----------------
    function automatic logic [31:0] m_shift(input logic [31:0] v);
        longint p;
        p = longint'(v) * 4;
        return p[31:0];
    endfunction

    function automatic logic [1:0] m_lost(input logic [31:0] v);
        return 2'(v / 32'h4000_0000);
    endfunction

    function automatic logic m_ovf(input logic [31:0] v);
        longint s;
        s = longint'($signed(v)) * 4;
        return (s > 64'sd2147483647) || (s < -64'sd2147483648);
    endfunction

    logic        m_valid = 1'b0;
    logic [31:0] m_q     = '0;
    logic [1:0]  m_lq    = '0;
    logic        m_oq    = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_q     <= '0;
            m_lq    <= '0;
            m_oq    <= 1'b0;
        end else if (in_valid && (!m_valid || q_ready)) begin
            m_valid <= 1'b1;
            m_q     <= m_shift(in);
            m_lq    <= m_lost(in);
            m_oq    <= m_ovf(in);
        end else if (m_valid && q_ready) begin
            m_valid <= 1'b0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (run_chk) begin
            chk("m.out",      out,                 m_shift(in));
            chk("m.in_ready", 32'(in_ready),       32'(!m_valid || q_ready));
            chk("m.q_valid",  32'(q_valid),        32'(m_valid));
            chk("m.q",        q,                   m_q);
            chk("m.q_lost",   32'(q_lost),         32'(m_lq));
            chk("m.q_ovf",    32'(q_ovf),          32'(m_oq));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic set(input logic [31:0] v, input logic iv, input logic qr);
        #1;
        in       = v;
        in_valid = iv;
        q_ready  = qr;
    endtask

    task automatic chk_q(input string name, input logic [31:0] eq, input logic [1:0] el,
                         input logic eo, input logic ev);
        chk({name, ".q"},       q,             eq);
        chk({name, ".q_lost"},  32'(q_lost),   32'(el));
        chk({name, ".q_ovf"},   32'(q_ovf),    32'(eo));
        chk({name, ".q_valid"}, 32'(q_valid),  32'(ev));
    endtask

    logic [31:0] sweep_in  [4] = '{32'h0, 32'h1, 32'h2, 32'h4};
    logic [31:0] sweep_out [4] = '{32'h0, 32'h4, 32'h8, 32'h10};
    logic [31:0] strm_out  [4] = '{32'h4, 32'h8, 32'hC, 32'h10};

    initial begin
        rst      = 1'b1;
        in       = '0;
        in_valid = 1'b0;
        q_ready  = 1'b0;

        // Combinational sweep while Rst is held and Clk toggles.
        for (int i = 0; i < 4; i++) begin
            in = sweep_in[i];
            #5;
            chk("sweep.out", out, sweep_out[i]);
        end
        #2;
        chk_q("reset", 32'h0, 2'd0, 1'b0, 1'b0);
        chk("reset.in_ready", 32'(in_ready), 32'd1);

        @(negedge clk);
        #1 rst = 1'b0;
        run_chk = 1'b1;

        // Register capture of boundary values.
        set(32'hFFFF_FFFF, 1'b1, 1'b1);
        @(negedge clk); chk_q("cap_ffff", 32'hFFFF_FFFC, 2'd3, 1'b0, 1'b1);
        set(32'h2000_0000, 1'b1, 1'b1);
        @(negedge clk); chk_q("cap_2000", 32'h8000_0000, 2'd0, 1'b1, 1'b1);
        set(32'h4000_0000, 1'b1, 1'b1);
        @(negedge clk); chk_q("cap_4000", 32'h0, 2'd1, 1'b1, 1'b1);

        // Backpressure.
        set(32'h0, 1'b0, 1'b1);
        @(negedge clk); chk_q("bp_empty", 32'h0, 2'd1, 1'b1, 1'b0);
        set(32'h3, 1'b1, 1'b0);
        @(negedge clk); chk_q("bp_cap3", 32'hC, 2'd0, 1'b0, 1'b1);
        chk("bp_cap3.in_ready", 32'(in_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            set(32'h5, 1'b1, 1'b0);
            @(negedge clk); chk_q("bp_hold", 32'hC, 2'd0, 1'b0, 1'b1);
            chk("bp_hold.in_ready", 32'(in_ready), 32'd0);
        end
        set(32'h5, 1'b1, 1'b1);
        @(negedge clk); chk_q("bp_release", 32'h14, 2'd0, 1'b0, 1'b1);

        // Streaming.
        for (int i = 0; i < 4; i++) begin
            set(32'(i + 1), 1'b1, 1'b1);
            @(negedge clk); chk_q("stream", strm_out[i], 2'd0, 1'b0, 1'b1);
        end

        // Drain only.
        set(32'h0, 1'b0, 1'b1);
        @(negedge clk); chk_q("drain", 32'h10, 2'd0, 1'b0, 1'b0);

        // Async reset mid-cycle while holding q=0x10.
        set(32'h4, 1'b1, 1'b0);
        @(negedge clk); chk_q("pre_rst", 32'h10, 2'd0, 1'b0, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk_q("async_rst", 32'h0, 2'd0, 1'b0, 1'b0);
        chk("async_rst.in_ready", 32'(in_ready), 32'd1);
        chk("async_rst.out", out, 32'h10);

        @(negedge clk);
        #1;
        rst      = 1'b0;
        in       = 32'h8000_0000;
        in_valid = 1'b1;
        q_ready  = 1'b1;
        @(negedge clk); chk_q("post_8000", 32'h0, 2'd2, 1'b1, 1'b1);
        set(32'hE000_0000, 1'b1, 1'b1);
        @(negedge clk); chk_q("cap_e000", 32'h8000_0000, 2'd3, 1'b0, 1'b1);
        set(32'h7FFF_FFFF, 1'b1, 1'b1);
        @(negedge clk); chk_q("cap_7fff", 32'hFFFF_FFFC, 2'd1, 1'b1, 1'b1);

        set(32'h0, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        run_chk = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
